apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_if.sv | 24 ++
 rtl/apb_master_bridge.sv | 124 ++++++++++++
 tb/tb_apb_master_bridge.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and the bridge FSM encoding.
// Bus widths are fixed at 32-bit address/data with 4 byte strobes.
package apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int WCNT_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [WCNT_W-1:0] wcnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_mst_state_e;

  // Wait counter sticks at all-ones instead of wrapping.
  function automatic wcnt_t sat_inc(input wcnt_t v);
    return (v == '1) ? v : v + wcnt_t'(1);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB3/APB4 bus bundle between one master and one slave.
interface apb_if;
  import apb_pkg::*;

  logic  PSEL;
  logic  PENABLE;
  addr_t PADDR;
  logic  PWRITE;
  data_t PWDATA;
  strb_t PSTRB;
  logic  PREADY;
  data_t PRDATA;
  logic  PSLVERR;

  modport mst_mp (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slv_mp (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge with a sticky
// wait-state timeout flag; the transfer always runs to PREADY.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic   PCLK,
  input  logic   PRESETn,
  input  logic   cmd_valid,
  output logic   cmd_ready,
  input  logic   cmd_write,
  input  addr_t  cmd_addr,
  input  data_t  cmd_wdata,
  input  strb_t  cmd_strb,
  output logic   rsp_valid,
  input  logic   rsp_ready,
  output data_t  rsp_rdata,
  output logic   rsp_slverr,
  output logic   timeout_err,
  apb_if.mst_mp  apb
);

  localparam wcnt_t TO_CNT = wcnt_t'(TIMEOUT);

  apb_mst_state_e r_state, w_state_nxt;

  addr_t r_addr;
  logic  r_write;
  data_t r_wdata;
  strb_t r_strb;
  wcnt_t r_wait_cnt;
  logic  r_rsp_valid;
  data_t r_rsp_rdata;
  logic  r_rsp_slverr;
  logic  r_timeout;

  logic  w_cmd_hs;
  logic  w_done;
  logic  w_stall;
  wcnt_t w_cnt_inc;
  logic  w_to_set;

  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_done    = (r_state == ST_ACCESS) && apb.PREADY;
  assign w_stall   = (r_state == ST_ACCESS) && !apb.PREADY;
  assign w_cnt_inc = sat_inc(r_wait_cnt);
  assign w_to_set  = w_stall && (w_cnt_inc == TO_CNT);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_cmd_hs) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (apb.PREADY) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Command capture: reads present zero data and zero strobes on the bus.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_cmd_hs) begin
      r_addr  <= cmd_addr;
      r_write <= cmd_write;
      r_wdata <= cmd_write ? cmd_wdata : '0;
      r_strb  <= cmd_write ? cmd_strb  : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_wait_cnt <= '0;
    end else if (w_stall) begin
      r_wait_cnt <= w_cnt_inc;
    end
  end

  // Set has priority over the handshake clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      r_timeout <= 1'b0;
    else if (w_to_set) r_timeout <= 1'b1;
    else if (w_cmd_hs) r_timeout <= 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_rdata  <= r_write ? '0 : apb.PRDATA;
      r_rsp_slverr <= apb.PSLVERR;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE) && !r_rsp_valid;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign timeout_err = r_timeout;

  assign apb.PSEL    = (r_state != ST_IDLE);
  assign apb.PENABLE = (r_state == ST_ACCESS);
  assign apb.PADDR   = r_addr;
  assign apb.PWRITE  = r_write;
  assign apb.PWDATA  = r_wdata;
  assign apb.PSTRB   = r_strb;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized transfers against a transaction-level expectation
// of the bridge (latency, held fields, timeout flag, reset behaviour).
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TO = 4;

  logic  PCLK = 1'b0;
  logic  PRESETn = 1'b0;
  logic  cmd_valid = 1'b0, cmd_write = 1'b0;
  addr_t cmd_addr = '0;
  data_t cmd_wdata = '0;
  strb_t cmd_strb = '0;
  logic  rsp_ready = 1'b0;
  logic  cmd_ready, rsp_valid, rsp_slverr, timeout_err;
  data_t rsp_rdata;

  int compared = 0;
  int mismatched = 0;
  bit model_to = 1'b0;

  apb_if bus ();

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .timeout_err(timeout_err),
    .apb(bus.mst_mp)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transfer: handshake, SETUP, nwait stalled ACCESS cycles, completion,
  // then hold cycles with rsp_ready low before the response is consumed.
  task automatic xfer(input bit wr, input addr_t addr, input data_t wd, input strb_t st,
                      input int nwait, input data_t prd, input bit serr, input int hold);
    data_t exp_wd, exp_rd;
    strb_t exp_st;
    exp_wd = wr ? wd : '0;
    exp_st = wr ? st : '0;
    exp_rd = wr ? '0 : prd;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    @(posedge PCLK); #1;
    model_to = 1'b0;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    cmd_write = 1'($urandom);
    chk("setup_psel", 32'(bus.PSEL), 1);
    chk("setup_penable", 32'(bus.PENABLE), 0);
    chk("setup_paddr", bus.PADDR, addr);
    chk("setup_pwrite", 32'(bus.PWRITE), 32'(wr));
    chk("setup_pwdata", bus.PWDATA, exp_wd);
    chk("setup_pstrb", 32'(bus.PSTRB), 32'(exp_st));
    chk("setup_cmd_ready", 32'(cmd_ready), 0);
    chk("setup_timeout_clr", 32'(timeout_err), 32'(model_to));
    // Slave outputs during SETUP must be ignored.
    bus.PREADY = 1'b1; bus.PRDATA = $urandom; bus.PSLVERR = 1'b1;
    @(posedge PCLK); #1;
    chk("access_psel", 32'(bus.PSEL), 1);
    chk("access_penable", 32'(bus.PENABLE), 1);
    chk("access_paddr", bus.PADDR, addr);
    chk("access_rsp_valid", 32'(rsp_valid), 0);
    for (int i = 0; i <= nwait; i++) begin
      bus.PREADY  = (i == nwait);
      bus.PRDATA  = (i == nwait) ? prd : data_t'($urandom);
      bus.PSLVERR = (i == nwait) ? serr : 1'($urandom);
      @(posedge PCLK); #1;
      if (i < nwait) begin
        if (i + 1 >= TO) model_to = 1'b1;
        chk("wait_psel", 32'(bus.PSEL), 1);
        chk("wait_penable", 32'(bus.PENABLE), 1);
        chk("wait_paddr", bus.PADDR, addr);
        chk("wait_pwdata", bus.PWDATA, exp_wd);
        chk("wait_pstrb", 32'(bus.PSTRB), 32'(exp_st));
        chk("wait_timeout", 32'(timeout_err), 32'(model_to));
        chk("wait_rsp_valid", 32'(rsp_valid), 0);
      end
    end
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = $urandom;
    chk("done_psel", 32'(bus.PSEL), 0);
    chk("done_penable", 32'(bus.PENABLE), 0);
    chk("done_rsp_valid", 32'(rsp_valid), 1);
    chk("done_rsp_rdata", rsp_rdata, exp_rd);
    chk("done_rsp_slverr", 32'(rsp_slverr), 32'(serr));
    chk("done_timeout", 32'(timeout_err), 32'(model_to));
    chk("idle_paddr_hold", bus.PADDR, addr);
    chk("idle_pstrb_hold", 32'(bus.PSTRB), 32'(exp_st));
    cmd_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge PCLK); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk("hold_rsp_slverr", 32'(rsp_slverr), 32'(serr));
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
      chk("hold_psel", 32'(bus.PSEL), 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("consumed_rsp_valid", 32'(rsp_valid), 0);
    chk("consumed_cmd_ready", 32'(cmd_ready), 1);
    chk("consumed_timeout", 32'(timeout_err), 32'(model_to));
  endtask

  initial begin
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", 32'(bus.PSEL), 0);
    chk("rst_penable", 32'(bus.PENABLE), 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwrite", 32'(bus.PWRITE), 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_pstrb", 32'(bus.PSTRB), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_slverr", 32'(rsp_slverr), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Zero-wait write: PSEL N+1, PENABLE N+2, rsp_valid N+3
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h1234_5678, 1'b0, 0);
    // Read with 3 wait states
    xfer(1'b0, 32'h10, 32'h5555_AAAA, 4'hF, 3, 32'hDEADBEEF, 1'b0, 0);
    // Response back-pressure for 10 cycles
    xfer(1'b0, 32'h20, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 1'b0, 10);
    // Timeout after 4 wait cycles, transfer still completes
    xfer(1'b1, 32'h30, 32'h0BAD_CAFE, 4'h5, 6, 32'h0, 1'b0, 0);
    // Slave error then clean read; handshake also clears the timeout flag
    xfer(1'b1, 32'h40, 32'h1111_2222, 4'hC, 0, 32'h0, 1'b1, 0);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 2, 32'h3333_4444, 1'b0, 0);
    // All-zero write strobe passes unmodified
    xfer(1'b1, 32'h48, 32'h7777_8888, 4'h0, 0, 32'h0, 1'b0, 1);

    for (int n = 0; n < 25; n++) begin
      xfer(1'($urandom), addr_t'($urandom), data_t'($urandom), strb_t'($urandom),
           $urandom_range(0, 6), data_t'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // Reset asserted during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'hFEED_BEEF; cmd_strb = 4'hF;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    bus.PREADY = 1'b0;
    @(posedge PCLK); #1;
    chk("pre_rst_penable", 32'(bus.PENABLE), 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(bus.PSEL), 0);
    chk("async_rst_penable", 32'(bus.PENABLE), 0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("async_rst_paddr", bus.PADDR, 0);
    bus.PREADY = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    bus.PREADY = 1'b0;
    @(posedge PCLK); #1;
    chk("after_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("after_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("after_rst_timeout", 32'(timeout_err), 0);
    model_to = 1'b0;
    xfer(1'b0, 32'h54, 32'h0, 4'hF, 1, 32'h9999_0000, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
